reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arbiter_pkg.sv | 19 +
 rtl/reg_bank_arbiter_if.sv | 46 ++++
 rtl/reg_bank_word.sv | 17 +
 rtl/reg_bank_arbiter.sv | 119 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared FSM state type, lock length and clog2 helper for reg_bank_arbiter.
// Optional lock feature: define REG_BANK_ARBITER_LOCK_EN.
package reg_bank_arbiter_pkg;

   typedef logic [0:0] state_t;

   localparam state_t IDLE  = 1'b0;
   localparam state_t GRANT = 1'b1;

   localparam int LOCK_MAX = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the register bank arbiter.
// Optional lock vector when REG_BANK_ARBITER_LOCK_EN is defined.
interface reg_bank_arbiter_if
   import reg_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);

   localparam int AW = clog2(DEPTH);
   localparam int IW = clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       we;
   logic [NREQ*AW-1:0]    addr;
   logic [NREQ*WIDTH-1:0] wdata;
`ifdef REG_BANK_ARBITER_LOCK_EN
   logic [NREQ-1:0]       lock;
`endif
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      rdata;
   logic                  rvalid;
   logic [IW-1:0]         rid;

`ifdef REG_BANK_ARBITER_LOCK_EN
   modport master (
      output req, we, addr, wdata, lock,
      input  gnt, rdata, rvalid, rid
   );
   modport slave (
      input  req, we, addr, wdata, lock,
      output gnt, rdata, rvalid, rid
   );
`else
   modport master (
      output req, we, addr, wdata,
      input  gnt, rdata, rvalid, rid
   );
   modport slave (
      input  req, we, addr, wdata,
      output gnt, rdata, rvalid, rid
   );
`endif

endinterface

// File: rtl/reg_bank_word.sv
// One bank register: async active-high reset, load on we.
module reg_bank_word #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= '0;
      else if (we) q <= d;
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a DEPTH-word bank.
// Define REG_BANK_ARBITER_LOCK_EN to add the per-requester lock input.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   reg_bank_arbiter_if.slave  bus
);

   localparam int AW = clog2(DEPTH);
   localparam int IW = clog2(NREQ);

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win;
   logic [IW-1:0]    pick;
   logic [IW-1:0]    nxt_ptr;
   logic             hold;
   logic             cur_we;
   logic [AW-1:0]    cur_addr;
   logic [WIDTH-1:0] cur_wdata;
   logic [WIDTH-1:0] rd_word;
   logic [DEPTH-1:0] wr_en;
   logic [WIDTH-1:0] q [DEPTH];

   // Scan from the farthest offset down so offset 0 from ptr wins.
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[(int'(ptr) + i) % NREQ])
            pick = IW'((int'(ptr) + i) % NREQ);
      end
   end

   assign cur_we    = bus.we[win];
   assign cur_addr  = bus.addr[int'(win)*AW +: AW];
   assign cur_wdata = bus.wdata[int'(win)*WIDTH +: WIDTH];
   assign nxt_ptr   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

   // Out-of-range addresses match no word: writes drop, reads give zero.
   always_comb begin
      rd_word = '0;
      wr_en   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (int'(cur_addr) == k) begin
            rd_word  = q[k];
            wr_en[k] = (state == GRANT) && cur_we;
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      reg_bank_word #(.WIDTH(WIDTH)) u_word (
         .clk   (clk),
         .reset (reset),
         .we    (wr_en[k]),
         .d     (cur_wdata),
         .q     (q[k])
      );
   end

`ifdef REG_BANK_ARBITER_LOCK_EN
   logic [2:0] lock_cnt;

   assign hold = bus.lock[win] &&
                 (int'(lock_cnt) < LOCK_MAX - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lock_cnt <= '0;
      else if (state == GRANT)
         lock_cnt <= hold ? lock_cnt + 3'd1 : 3'd0;
   end
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         win        <= '0;
         bus.gnt    <= '0;
         bus.rdata  <= '0;
         bus.rvalid <= 1'b0;
         bus.rid    <= '0;
      end else begin
         bus.rvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|bus.req) begin
                  win     <= pick;
                  bus.gnt <= NREQ'(1) << pick;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (!cur_we) begin
                  bus.rdata  <= rd_word;
                  bus.rvalid <= 1'b1;
                  bus.rid    <= win;
               end
               if (!hold) begin
                  state   <= IDLE;
                  bus.gnt <= '0;
                  ptr     <= nxt_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: transaction-level model predicts
// grants and read returns; a monitor compares every cycle.
`timescale 1ns/1ps
module tb_reg_bank_arbiter;
   import reg_bank_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 6;
   localparam int AW    = clog2(DEPTH);

   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reg_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int cyc;
      int id;
   } gexp_t;

   typedef struct {
      int cyc;
      int id;
      int data;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t g;
   rexp_t r;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit         act    [NREQ];
   bit         t_we   [NREQ];
   int         t_addr [NREQ];
   logic [7:0] t_data [NREQ];
   bit         lk     [NREQ];

   int         mptr;
   logic [7:0] mbank [DEPTH];
   bit         busy;
   int         mw;
   int         glen;
   bit         rand_en = 0;
   bit         sticky  = 0;
   bit         chk_rd0 = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] a,
                        input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, a, e, cyc);
      end
   endtask

   // Monitor: pops whatever the model promised for this cycle.
   always @(negedge clk) begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
         g = gq.pop_front();
         check("gnt", 32'(bus.gnt), 32'(1) << g.id);
      end else begin
         check("gnt_idle", 32'(bus.gnt), 32'd0);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
         r = rq.pop_front();
         check("rvalid", 32'(bus.rvalid), 32'd1);
         check("rid", 32'(bus.rid), 32'(r.id));
         check("rdata", 32'(bus.rdata), 32'(r.data));
      end else begin
         check("rvalid_idle", 32'(bus.rvalid), 32'd0);
      end
      if (chk_rd0) check("rdata_rst", 32'(bus.rdata), 32'd0);
   end

   task automatic set_txn(input int i, input bit w, input int a,
                          input logic [7:0] d);
      act[i]    = 1'b1;
      t_we[i]   = w;
      t_addr[i] = a;
      t_data[i] = d;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.req[i] = act[i];
         // Dropping req mid-grant must not cancel the access.
         if (busy && mw == i && $urandom_range(0, 1) == 1)
            bus.req[i] = 1'b0;
         bus.we[i] = t_we[i];
         bus.addr[i*AW +: AW] = AW'(t_addr[i]);
         bus.wdata[i*WIDTH +: WIDTH] = t_data[i];
`ifdef REG_BANK_ARBITER_LOCK_EN
         bus.lock[i] = lk[i];
`endif
      end
   endtask

   // Model of the upcoming clock edge, from the arbitration rules.
   task automatic step_model(output int fin);
      bit found;
      int j;
      fin = -1;
      if (!busy) begin
         found = 0;
         for (int k = 0; k < NREQ; k++) begin
            j = (mptr + k) % NREQ;
            if (!found && act[j]) begin
               found = 1;
               mw = j;
            end
         end
         if (found) begin
            busy = 1;
            glen = 0;
            gq.push_back('{cyc + 1, mw});
         end
      end else begin
         if (t_we[mw]) begin
            if (t_addr[mw] < DEPTH) mbank[t_addr[mw]] = t_data[mw];
         end else begin
            rq.push_back('{cyc + 1, mw,
               (t_addr[mw] < DEPTH) ? int'(mbank[t_addr[mw]]) : 0});
         end
         glen++;
`ifdef REG_BANK_ARBITER_LOCK_EN
         if (lk[mw] && glen < LOCK_MAX) begin
            gq.push_back('{cyc + 1, mw});
         end else begin
            busy = 0;
            mptr = (mw + 1) % NREQ;
            fin  = mw;
         end
`else
         busy = 0;
         mptr = (mw + 1) % NREQ;
         fin  = mw;
`endif
      end
   endtask

   task automatic run(input int n);
      int fin;
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (!act[i] && (sticky || (rand_en && $urandom_range(0, 3) == 0)))
               set_txn(i, sticky ? 1'b0 : 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), 8'($urandom));
`ifdef REG_BANK_ARBITER_LOCK_EN
            if (rand_en) lk[i] = ($urandom_range(0, 3) == 0);
`endif
         end
         drive();
         step_model(fin);
         if (fin >= 0) act[fin] = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      #2;
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         act[i] = 0;
         lk[i]  = 0;
      end
      for (int k = 0; k < DEPTH; k++) mbank[k] = 8'h00;
      busy = 0;
      mptr = 0;
      gq.delete();
      rq.delete();
      drive();
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached, got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         t_we[i]   = 0;
         t_addr[i] = 0;
         t_data[i] = 0;
      end
      do_reset(2);

      chk_rd0 = 1;
      run(10);
      chk_rd0 = 0;

      set_txn(0, 1, 3, 8'hA5);
      run(4);
      set_txn(0, 0, 3, 8'h00);
      run(4);

      do_reset(2);
      sticky = 1;
      run(10);
      sticky = 0;
      run(12);

      do_reset(2);
      set_txn(2, 1, 5, 8'h5A);
      run(4);
      set_txn(2, 0, 5, 8'h00);
      run(4);
      set_txn(2, 0, 0, 8'h00);
      set_txn(3, 0, 5, 8'h00);
      run(6);

      do_reset(2);
      set_txn(0, 1, 1, 8'h3C);
      run(4);
      set_txn(0, 1, 1, 8'hFF);
      run(1);
      @(negedge clk);
      do_reset(2);
      set_txn(0, 0, 1, 8'h00);
      run(4);

      set_txn(1, 1, 6, 8'h77);
      run(4);
      set_txn(1, 0, 6, 8'h00);
      run(4);
      set_txn(3, 0, 7, 8'h00);
      run(4);

`ifdef REG_BANK_ARBITER_LOCK_EN
      do_reset(2);
      set_txn(1, 0, 2, 8'h00);
      lk[1] = 1;
      run(6);
      lk[1] = 0;
      set_txn(0, 0, 3, 8'h00);
      set_txn(3, 1, 4, 8'h11);
      run(8);
`endif

      do_reset(2);
      rand_en = 1;
      run(3000);
      rand_en = 0;
      for (int i = 0; i < NREQ; i++) lk[i] = 0;
      run(40);

      @(negedge clk);
      #1;
      check("gnt_queue_drained", 32'(gq.size()), 32'd0);
      check("rd_queue_drained", 32'(rq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
